// File: rtl/alu4_pkg.sv
// Shared constants and types for the 4-bit 74181-style ALU.
// Optional feature macro used by the top: ALU4_ENABLE_EN.
package alu4_pkg;

    typedef logic [3:0] word_t;

    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

    // Logic-mode opcodes
    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1110;
    localparam logic [3:0] OP_ONES = 4'b1111;

    // Arithmetic-mode opcodes
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_DBL  = 4'b1100;

endpackage

// File: rtl/alu4_adder.sv
// 4-bit adder: sum = x + y + cin, carry out of bit 3, signed overflow.
// Ports: x_i, y_i, cin_i in; sum_o, co_o, v_o out.
module alu4_adder
    import alu4_pkg::*;
(
    input  word_t x_i,
    input  word_t y_i,
    input  logic  cin_i,
    output word_t sum_o,
    output logic  co_o,
    output logic  v_o
);

    logic [4:0] full;

    assign full  = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, cin_i};
    assign sum_o = full[3:0];
    assign co_o  = full[4];
    // Same-signed operands producing a differently-signed result
    assign v_o   = (x_i[3] == y_i[3]) && (full[3] != x_i[3]);

endmodule

// File: rtl/alu4_unit.sv
// Registered 4-bit ALU: 16 logic (m=0) and 16 arithmetic (m=1) functions.
// Ports: clk, rst (sync, high), [en if ALU4_ENABLE_EN], a, b, cin, m, s in;
//        dout, co, v, z out (all registered, 1-cycle latency).
module alu4_unit
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
`ifdef ALU4_ENABLE_EN
    input  logic       en,
`endif
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       m,
    input  logic [3:0] s,
    output logic [3:0] dout,
    output logic       co,
    output logic       v,
    output logic       z
);

    word_t lres;
    word_t x;
    word_t y;
    word_t sum;
    logic  add_co;
    logic  add_v;
    logic  load;

    word_t dout_d, dout_q;
    logic  co_d, co_q;
    logic  v_d, v_q;
    logic  z_d, z_q;

    always_comb begin
        lres = 4'b0000;
        unique case (s)
            4'b0000: lres = 4'b0000;
            4'b0001: lres = ~a & ~b;
            4'b0010: lres = ~a & b;
            4'b0011: lres = ~a;
            4'b0100: lres = a & ~b;
            4'b0101: lres = ~b;
            4'b0110: lres = a ^ b;
            4'b0111: lres = ~a | ~b;
            4'b1000: lres = a & b;
            4'b1001: lres = ~(a ^ b);
            4'b1010: lres = b;
            4'b1011: lres = ~a | b;
            4'b1100: lres = a;
            4'b1101: lres = a | ~b;
            4'b1110: lres = a | b;
            4'b1111: lres = 4'b1111;
            default: lres = 4'b0000;
        endcase
    end

    always_comb begin
        x = a;
        y = 4'b0000;
        unique case (s)
            4'b0000: begin x = a;       y = 4'b0000; end
            4'b0001: begin x = a | b;   y = 4'b0000; end
            4'b0010: begin x = a | ~b;  y = 4'b0000; end
            4'b0011: begin x = 4'b1111; y = 4'b0000; end
            4'b0100: begin x = a;       y = a & ~b;  end
            4'b0101: begin x = a | b;   y = a & ~b;  end
            4'b0110: begin x = a;       y = ~b;      end
            4'b0111: begin x = a & ~b;  y = 4'b1111; end
            4'b1000: begin x = a;       y = a & b;   end
            4'b1001: begin x = a;       y = b;       end
            4'b1010: begin x = a | ~b;  y = a & b;   end
            4'b1011: begin x = a & b;   y = 4'b1111; end
            4'b1100: begin x = a;       y = a;       end
            4'b1101: begin x = a | b;   y = a;       end
            4'b1110: begin x = a | ~b;  y = a;       end
            4'b1111: begin x = a;       y = 4'b1111; end
            default: begin x = a;       y = 4'b0000; end
        endcase
    end

    alu4_adder u_adder (
        .x_i   (x),
        .y_i   (y),
        .cin_i (cin),
        .sum_o (sum),
        .co_o  (add_co),
        .v_o   (add_v)
    );

    always_comb begin
        dout_d = lres;
        co_d   = 1'b0;
        v_d    = 1'b0;
        if (m == MODE_ARITH) begin
            dout_d = sum;
            co_d   = add_co;
            v_d    = add_v;
        end
        z_d = (dout_d == 4'b0000);
    end

`ifdef ALU4_ENABLE_EN
    assign load = en;
`else
    assign load = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= 4'b0000;
            co_q   <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b1;
        end else if (load) begin
            dout_q <= dout_d;
            co_q   <= co_d;
            v_q    <= v_d;
            z_q    <= z_d;
        end
    end

    assign dout = dout_q;
    assign co   = co_q;
    assign v    = v_q;
    assign z    = z_q;

endmodule

// File: tb/tb_alu4_unit.sv
// Scoreboard bench for alu4_unit: driver pushes expected results,
// monitor pops and compares one cycle after each applied operation.
module tb_alu4_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] a, b, s;
    logic       cin, m;
    logic [3:0] dout;
    logic       co, v, z;

    typedef struct {
        logic [3:0] d;
        logic       c;
        logic       v;
        logic       z;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu4_unit dut (
        .clk  (clk),
        .rst  (rst),
`ifdef ALU4_ENABLE_EN
        .en   (en),
`endif
        .a    (a),
        .b    (b),
        .cin  (cin),
        .m    (m),
        .s    (s),
        .dout (dout),
        .co   (co),
        .v    (v),
        .z    (z)
    );

    always #5 clk = ~clk;

    task automatic drive(
        input logic       r,
        input logic [3:0] ia,
        input logic [3:0] ib,
        input logic       ic,
        input logic       im,
        input logic [3:0] is,
        input logic [3:0] ed,
        input logic       ec,
        input logic       ev,
        input string      nm,
        input logic       ien = 1'b1
    );
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = ia;
        b   = ib;
        cin = ic;
        m   = im;
        s   = is;
        en  = ien;
        e.d  = ed;
        e.c  = ec;
        e.v  = ev;
        e.z  = (ed == 4'b0000);
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: one result per clock edge after each pushed stimulus
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (dout !== e.d || co !== e.c || v !== e.v || z !== e.z) begin
                    errors++;
                    $display("FAIL %s: got dout=%b co=%b v=%b z=%b, expected dout=%b co=%b v=%b z=%b",
                             e.nm, dout, co, v, z, e.d, e.c, e.v, e.z);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [3:0] lexp [16];
        logic [4:0] sum5;
        int         sa, sb_i, sv;
        logic [3:0] ta, tb;

        lexp = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                 4'b1100, 4'b1101, 4'b1110, 4'b1111};

        rst = 1'b1; en = 1'b1;
        a = '0; b = '0; cin = 1'b0; m = 1'b0; s = '0;

        drive(1, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0000, 0, 0, "reset0");
        drive(1, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0000, 0, 0, "reset1");

        for (int i = 0; i < 16; i++)
            drive(0, 4'b1100, 4'b1010, 1, 0, 4'(i), lexp[i], 0, 0,
                  $sformatf("logic_s%0d", i));

        drive(0, 4'b1100, 4'b1010, 1, 1, 4'b0110, 4'b0010, 1, 0, "sub_c");
        drive(0, 4'b1100, 4'b0110, 0, 1, 4'b1001, 4'b0010, 1, 0, "add_co1");
        drive(0, 4'b0100, 4'b0110, 0, 1, 4'b1001, 4'b1010, 0, 1, "add_co0");

        drive(0, 4'b0111, 4'b0010, 0, 1, 4'b1001, 4'b1001, 0, 1, "addv_a");
        drive(0, 4'b0111, 4'b1010, 0, 1, 4'b1001, 4'b0001, 1, 0, "addv_b");
        drive(0, 4'b1100, 4'b1010, 0, 1, 4'b1001, 4'b0110, 1, 1, "addv_c");
        drive(0, 4'b1100, 4'b0110, 0, 1, 4'b1001, 4'b0010, 1, 0, "addv_d");

        drive(0, 4'b0111, 4'b0010, 1, 1, 4'b0110, 4'b0101, 1, 0, "subv_a");
        drive(0, 4'b0111, 4'b1010, 1, 1, 4'b0110, 4'b1101, 0, 1, "subv_b");
        drive(0, 4'b1100, 4'b1010, 1, 1, 4'b0110, 4'b0010, 1, 0, "subv_c");
        drive(0, 4'b1100, 4'b0110, 1, 1, 4'b0110, 4'b0110, 1, 1, "subv_d");

        // Exhaustive add with a reset pulse partway through
        for (int i = 0; i < 256; i++) begin
            ta   = 4'(i >> 4);
            tb   = 4'(i & 15);
            sum5 = {1'b0, ta} + {1'b0, tb};
            sa   = (ta > 7) ? int'(ta) - 16 : int'(ta);
            sb_i = (tb > 7) ? int'(tb) - 16 : int'(tb);
            sv   = sa + sb_i;
            if (i == 100)
                drive(1, 4'b1111, 4'b1111, 1, 1, 4'b1001, 4'b0000, 0, 0, "rst_mid");
            drive(0, ta, tb, 0, 1, 4'b1001, sum5[3:0], sum5[4],
                  (sv > 7 || sv < -8), $sformatf("add_%0d_%0d", ta, tb));
        end

`ifdef ALU4_ENABLE_EN
        drive(0, 4'b0011, 4'b0100, 0, 1, 4'b1001, 4'b0111, 0, 0, "en_load");
        drive(0, 4'b1111, 4'b0001, 0, 1, 4'b1001, 4'b0111, 0, 0, "en_hold0", 1'b0);
        drive(0, 4'b1000, 4'b1000, 0, 1, 4'b1001, 4'b0111, 0, 0, "en_hold1", 1'b0);
        drive(1, 4'b1000, 4'b1000, 0, 1, 4'b1001, 4'b0000, 0, 0, "en_rst", 1'b0);
`endif

        drive(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, "logic_zero");

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
